apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
// APB master bridging a simple request port (trans_i/addr_i/wdata_i/wr_rd_i)
// onto an APB slave bus (psel/penable/pwrite/paddr/pwdata, pready/prdata/pslverr).
// Runs the IDLE->SETUP->ACCESS protocol, returns read data and a per-transfer
// error flag to the requester. Sits between the system-side bridge and one APB slave (memory).
// PARAMETERS
// ADDR_WIDTH  8   width of addr_i / paddr
// DATA_WIDTH  32  width of wdata_i, pwdata, prdata, rdata_o
// PORTS
// pclk         in   1           clock, all logic on rising edge
// preset_n     in   1           reset, synchronous, active-low
// trans_i      in   1           transfer request from bridge (level)
// addr_i       in   ADDR_WIDTH  transfer address
// wdata_i      in   DATA_WIDTH  write data
// wr_rd_i      in   1           1 = write, 0 = read
// pready       in   1           slave ready (wait states while low)
// pslverr      in   1           slave error, valid only when pready=1 in ACCESS
// prdata       in   DATA_WIDTH  slave read data, valid when pready=1 in ACCESS
// pselx        out  1           APB select
// penable      out  1           APB enable
// pwrite       out  1           APB direction
// paddr        out  ADDR_WIDTH  APB address
// pwdata       out  DATA_WIDTH  APB write data
// rdata_o      out  DATA_WIDTH  last completed read data to bridge
// trans_err_o  out  1           error pulse for completed transfer
// BEHAVIOUR
// - All outputs registered. Reset (preset_n=0 at an edge, any state): state=IDLE,
//   every output 0. Reset mid-transfer aborts it; no completion, no error pulse.
// - FSM states IDLE, SETUP, ACCESS:
//   IDLE:   pselx=0,penable=0. trans_i=1 at edge -> SETUP; latch addr_i/wdata_i/wr_rd_i
//           into paddr/pwdata/pwrite at that edge.
//   SETUP:  pselx=1,penable=0, exactly one cycle -> ACCESS unconditionally.
//   ACCESS: pselx=1,penable=1. pready=0 -> stay (wait states, all APB outputs held).
//           pready=1 -> transfer completes at that edge:
//             trans_i=1 -> SETUP (back-to-back, relatch request, penable drops to 0);
//             trans_i=0 -> IDLE (pselx,penable -> 0).
// - Request inputs ignored in SETUP and ACCESS except at the completing edge; no queue.
// - paddr/pwrite/pwdata stable from SETUP through end of ACCESS; hold last value in IDLE.
//   pwdata driven with latched wdata_i even on reads.
// - Completion of read (pwrite=0): rdata_o <= prdata at completing edge; holds until
//   next completed read. Writes leave rdata_o unchanged. Read with pslverr=1 still updates.
// - trans_err_o <= pslverr at completing edge, for exactly one cycle; 0 otherwise.
// - Latency: request sampled at edge N -> SETUP after N, ACCESS after N+1; zero-wait
//   transfer completes at edge N+2; rdata_o/trans_err_o valid after N+2.
// - pslverr/prdata ignored outside ACCESS or when pready=0.
// TESTING
// - Reset: preset_n=0 2 cycles with trans_i=1 -> all outputs 0, pselx never asserts.
// - Zero-wait write addr=0x10 data=0xDEADBEEF -> pselx 2 cycles, penable 1 cycle,
//   pwrite=1 paddr=0x10 pwdata=0xDEADBEEF, trans_err_o=0.
// - Read addr=0x10, pready low 3 cycles, prdata=0xDEADBEEF -> ACCESS held 4 cycles,
//   rdata_o=0xDEADBEEF after completion, paddr stable throughout.
// - Write with pslverr=1 on completion -> trans_err_o high exactly 1 cycle.
// - trans_i held high for write 0x04 then read 0x08 -> SETUP immediately after first
//   ACCESS (no IDLE), penable 1->0->1, paddr 0x04 then 0x08.
// - preset_n=0 during ACCESS with pready=0 -> next edge IDLE, outputs 0, no error pulse.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB master bridge: converts a level-style request port into an APB
// IDLE -> SETUP -> ACCESS transfer, returning read data and an error pulse.
module apb_master_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  trans_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  wr_rd_i,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [DATA_WIDTH-1:0] prdata,
    output logic                  pselx,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  trans_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic                    pselx_reg, pselx_next;
    logic                    penable_reg, penable_next;
    logic                    pwrite_reg, pwrite_next;
    logic [ADDR_WIDTH-1:0]   paddr_reg, paddr_next;
    logic [DATA_WIDTH-1:0]   pwdata_reg, pwdata_next;
    logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
    logic                    err_reg, err_next;

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state_reg   <= ST_IDLE;
            pselx_reg   <= 1'b0;
            penable_reg <= 1'b0;
            pwrite_reg  <= 1'b0;
            paddr_reg   <= '0;
            pwdata_reg  <= '0;
            rdata_reg   <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pselx_reg   <= pselx_next;
            penable_reg <= penable_next;
            pwrite_reg  <= pwrite_next;
            paddr_reg   <= paddr_next;
            pwdata_reg  <= pwdata_next;
            rdata_reg   <= rdata_next;
            err_reg     <= err_next;
        end
    end

    // Next-state logic; APB strobes are derived from the next state so that
    // they come straight out of flops and line up with the state register.
    always_comb begin
        state_next  = state_reg;
        pwrite_next = pwrite_reg;
        paddr_next  = paddr_reg;
        pwdata_next = pwdata_reg;
        rdata_next  = rdata_reg;
        err_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (trans_i) begin
                    state_next  = ST_SETUP;
                    pwrite_next = wr_rd_i;
                    paddr_next  = addr_i;
                    pwdata_next = wdata_i;
                end
            end
            ST_SETUP: begin
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    // Completing edge: capture response, then either chain
                    // straight into the next SETUP or fall back to IDLE.
                    err_next = pslverr;
                    if (!pwrite_reg) begin
                        rdata_next = prdata;
                    end
                    if (trans_i) begin
                        state_next  = ST_SETUP;
                        pwrite_next = wr_rd_i;
                        paddr_next  = addr_i;
                        pwdata_next = wdata_i;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        pselx_next   = (state_next != ST_IDLE);
        penable_next = (state_next == ST_ACCESS);
    end

    assign pselx       = pselx_reg;
    assign penable     = penable_reg;
    assign pwrite      = pwrite_reg;
    assign paddr       = paddr_reg;
    assign pwdata      = pwdata_reg;
    assign rdata_o     = rdata_reg;
    assign trans_err_o = err_reg;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: reset, zero-wait write, wait-state
// read, error write, back-to-back transfers and reset during ACCESS.
module tb_apb_master_bridge;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          pclk = 1'b0;
    logic          preset_n;
    logic          trans_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wdata_i;
    logic          wr_rd_i;
    logic          pready;
    logic          pslverr;
    logic [DW-1:0] prdata;
    logic          pselx;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] rdata_o;
    logic          trans_err_o;

    int checks = 0;
    int errors = 0;

    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .trans_i     (trans_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .wr_rd_i     (wr_rd_i),
        .pready      (pready),
        .pslverr     (pslverr),
        .prdata      (prdata),
        .pselx       (pselx),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .rdata_o     (rdata_o),
        .trans_err_o (trans_err_o)
    );

    always #5 pclk = ~pclk;

    // Advance one rising edge and settle past it before sampling/driving.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the full APB/bridge output set in one line.
    task automatic chk_all(input string tag, input logic s, input logic e, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] r, input logic er);
        chk({tag, ".pselx"},   {31'd0, pselx},   {31'd0, s});
        chk({tag, ".penable"}, {31'd0, penable}, {31'd0, e});
        chk({tag, ".pwrite"},  {31'd0, pwrite},  {31'd0, w});
        chk({tag, ".paddr"},   {24'd0, paddr},   {24'd0, a});
        chk({tag, ".pwdata"},  pwdata,           d);
        chk({tag, ".rdata"},   rdata_o,          r);
        chk({tag, ".err"},     {31'd0, trans_err_o}, {31'd0, er});
        $display("step %-14s pselx=%b penable=%b pwrite=%b paddr=%h pwdata=%h rdata=%h err=%b",
                 tag, pselx, penable, pwrite, paddr, pwdata, rdata_o, trans_err_o);
    endtask

    initial begin
        preset_n = 1'b0;
        trans_i  = 1'b1;
        addr_i   = 8'h10;
        wdata_i  = 32'hDEADBEEF;
        wr_rd_i  = 1'b1;
        pready   = 1'b1;
        pslverr  = 1'b0;
        prdata   = 32'h0;

        // Reset held 2 cycles with a pending request: nothing may start.
        tick();
        chk_all("rst0", 0, 0, 0, 8'h00, 32'h0, 32'h0, 0);
        tick();
        chk_all("rst1", 0, 0, 0, 8'h00, 32'h0, 32'h0, 0);

        // Zero-wait write 0x10 <= DEADBEEF.
        preset_n = 1'b1;
        tick();
        chk_all("wr.setup", 1, 0, 1, 8'h10, 32'hDEADBEEF, 32'h0, 0);
        trans_i = 1'b0;
        tick();
        chk_all("wr.access", 1, 1, 1, 8'h10, 32'hDEADBEEF, 32'h0, 0);
        tick();
        chk_all("wr.done", 0, 0, 1, 8'h10, 32'hDEADBEEF, 32'h0, 0);

        // Read 0x10 with 3 wait states; pwdata carries the latched wdata.
        trans_i = 1'b1;
        addr_i  = 8'h10;
        wr_rd_i = 1'b0;
        wdata_i = 32'h12345678;
        pready  = 1'b0;
        prdata  = 32'hDEADBEEF;
        tick();
        chk_all("rd.setup", 1, 0, 0, 8'h10, 32'h12345678, 32'h0, 0);
        trans_i = 1'b0;
        addr_i  = 8'h55;
        tick();
        chk_all("rd.acc0", 1, 1, 0, 8'h10, 32'h12345678, 32'h0, 0);
        tick();
        chk_all("rd.acc1", 1, 1, 0, 8'h10, 32'h12345678, 32'h0, 0);
        tick();
        chk_all("rd.acc2", 1, 1, 0, 8'h10, 32'h12345678, 32'h0, 0);
        tick();
        chk_all("rd.acc3", 1, 1, 0, 8'h10, 32'h12345678, 32'h0, 0);
        pready = 1'b1;
        tick();
        chk_all("rd.done", 0, 0, 0, 8'h10, 32'h12345678, 32'hDEADBEEF, 0);

        // Write 0x20 with slave error: one-cycle error pulse, rdata unchanged.
        trans_i = 1'b1;
        addr_i  = 8'h20;
        wr_rd_i = 1'b1;
        wdata_i = 32'hCAFEF00D;
        pslverr = 1'b1;
        prdata  = 32'h0BADF00D;
        tick();
        chk_all("err.setup", 1, 0, 1, 8'h20, 32'hCAFEF00D, 32'hDEADBEEF, 0);
        trans_i = 1'b0;
        tick();
        chk_all("err.access", 1, 1, 1, 8'h20, 32'hCAFEF00D, 32'hDEADBEEF, 0);
        tick();
        chk_all("err.done", 0, 0, 1, 8'h20, 32'hCAFEF00D, 32'hDEADBEEF, 1);
        tick();
        chk_all("err.after", 0, 0, 1, 8'h20, 32'hCAFEF00D, 32'hDEADBEEF, 0);
        pslverr = 1'b0;

        // Back-to-back: write 0x04 then read 0x08 with trans_i held high.
        trans_i = 1'b1;
        addr_i  = 8'h04;
        wr_rd_i = 1'b1;
        wdata_i = 32'h11111111;
        prdata  = 32'hA5A5A5A5;
        tick();
        chk_all("b2b.setup1", 1, 0, 1, 8'h04, 32'h11111111, 32'hDEADBEEF, 0);
        addr_i  = 8'h08;
        wr_rd_i = 1'b0;
        wdata_i = 32'h22222222;
        tick();
        chk_all("b2b.acc1", 1, 1, 1, 8'h04, 32'h11111111, 32'hDEADBEEF, 0);
        tick();
        chk_all("b2b.setup2", 1, 0, 0, 8'h08, 32'h22222222, 32'hDEADBEEF, 0);
        trans_i = 1'b0;
        tick();
        chk_all("b2b.acc2", 1, 1, 0, 8'h08, 32'h22222222, 32'hDEADBEEF, 0);
        tick();
        chk_all("b2b.done", 0, 0, 0, 8'h08, 32'h22222222, 32'hA5A5A5A5, 0);

        // Reset during ACCESS with pready low: abort, all outputs cleared.
        trans_i = 1'b1;
        addr_i  = 8'h30;
        wr_rd_i = 1'b0;
        wdata_i = 32'h33333333;
        pready  = 1'b0;
        tick();
        chk_all("abort.setup", 1, 0, 0, 8'h30, 32'h33333333, 32'hA5A5A5A5, 0);
        trans_i = 1'b0;
        tick();
        chk_all("abort.access", 1, 1, 0, 8'h30, 32'h33333333, 32'hA5A5A5A5, 0);
        preset_n = 1'b0;
        pslverr  = 1'b1;
        tick();
        chk_all("abort.rst", 0, 0, 0, 8'h00, 32'h0, 32'h0, 0);
        preset_n = 1'b1;
        pready   = 1'b1;
        tick();
        chk_all("abort.idle", 0, 0, 0, 8'h00, 32'h0, 32'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
